qr_givens_sched: RTL and testbench

QR_GIVENS_SCHED -- requirements
Module: qr_givens_sched

---
 rtl/qr_givens_sched.sv | 121 ++++++++++++
 tb/tb_qr_givens_sched.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qr_givens_sched.sv
// Command scheduler for an 8x4 Givens-rotation QR on one shared CORDIC rotator.
// Optional QR_SCHED_PERF_EN adds a saturating stall_cnt output.
module qr_givens_sched (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       op_valid,
  input  logic       op_ready,
  input  logic       op_done,
  output logic       op_mode,
  output logic [2:0] op_row_p,
  output logic [2:0] op_row_q,
  output logic [1:0] op_col,
  output logic [5:0] op_idx,
  output logic       err
`ifdef QR_SCHED_PERF_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t     state;
  logic [1:0] piv_col;
  logic       start_ok;
  logic       last_cmd;

  assign start_ok = start && ((state == IDLE) || (state == DONE));
  assign last_cmd = (op_idx == 6'd59);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      op_valid <= 1'b0;
      op_mode  <= 1'b0;
      op_row_p <= 3'd0;
      op_row_q <= 3'd0;
      op_col   <= 2'd0;
      op_idx   <= 6'd0;
      err      <= 1'b0;
      piv_col  <= 2'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            state    <= ISSUE;
            busy     <= 1'b1;
            op_valid <= 1'b1;
            op_mode  <= 1'b0;
            op_row_p <= 3'd6;
            op_row_q <= 3'd7;
            op_col   <= 2'd0;
            op_idx   <= 6'd0;
            piv_col  <= 2'd0;
            err      <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          if (op_ready) begin
            op_valid <= 1'b0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (op_done) begin
            if (last_cmd) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state    <= ISSUE;
              op_valid <= 1'b1;
              op_idx   <= op_idx + 6'd1;
              // Sweep rotation columns right of the pivot, then move up one row pair,
              // then advance the pivot column and restart from the bottom rows.
              if (op_col != 2'd3) begin
                op_col  <= op_col + 2'd1;
                op_mode <= 1'b1;
              end else if (op_row_q != ({1'b0, piv_col} + 3'd1)) begin
                op_row_q <= op_row_q - 3'd1;
                op_row_p <= op_row_p - 3'd1;
                op_col   <= piv_col;
                op_mode  <= 1'b0;
              end else begin
                piv_col  <= piv_col + 2'd1;
                op_row_q <= 3'd7;
                op_row_p <= 3'd6;
                op_col   <= piv_col + 2'd1;
                op_mode  <= 1'b0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
      // A completion with nothing outstanding is a protocol error; it wins over a clearing start.
      if (op_done && (state != WAIT))
        err <= 1'b1;
    end
  end

`ifdef QR_SCHED_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= 16'd0;
    else if (start_ok)
      stall_cnt <= 16'd0;
    else if ((state == ISSUE) && !op_ready && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_qr_givens_sched.sv
// Directed bench for qr_givens_sched: full sequences, stall hold, ignored restart,
// back-to-back start, mid-sequence reset. Checks stall_cnt when QR_SCHED_PERF_EN is defined.
module tb_qr_givens_sched;

  logic       clk = 1'b0;
  logic       rst, start, op_ready, op_done;
  logic       busy, done, op_valid, op_mode, err;
  logic [2:0] op_row_p, op_row_q;
  logic [1:0] op_col;
  logic [5:0] op_idx;
`ifdef QR_SCHED_PERF_EN
  logic [15:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  logic       exp_mode [60];
  logic [2:0] exp_p    [60];
  logic [2:0] exp_q    [60];
  logic [1:0] exp_c    [60];

  always #5 clk = ~clk;

  qr_givens_sched dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_done  (op_done),
    .op_mode  (op_mode),
    .op_row_p (op_row_p),
    .op_row_q (op_row_q),
    .op_col   (op_col),
    .op_idx   (op_idx),
    .err      (err)
`ifdef QR_SCHED_PERF_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  // Reference command list straight from the column/row loop nest.
  task automatic build_model;
    int n;
    n = 0;
    for (int j = 0; j < 4; j++)
      for (int q = 7; q >= j + 1; q--) begin
        exp_mode[n] = 1'b0; exp_p[n] = 3'(q - 1); exp_q[n] = 3'(q); exp_c[n] = 2'(j);
        n++;
        for (int k = j + 1; k < 4; k++) begin
          exp_mode[n] = 1'b1; exp_p[n] = 3'(q - 1); exp_q[n] = 3'(q); exp_c[n] = 2'(k);
          n++;
        end
      end
  endtask

  // Rotator model: optional stall, handshake, op_done two cycles after acceptance.
  task automatic serve_cmd(input int stall, input bit pulse_start, output bit got,
                           output logic m, output logic [2:0] p, output logic [2:0] q,
                           output logic [1:0] c, output logic [5:0] idx,
                           output bit stable, output bit done_seen);
    got = 1'b0; stable = 1'b1; done_seen = 1'b0;
    m = 1'b0; p = 3'd0; q = 3'd0; c = 2'd0; idx = 6'd0;
    for (int w = 0; w < 50 && !op_valid; w++) @(negedge clk);
    if (op_valid !== 1'b1) return;
    got = 1'b1;
    m = op_mode; p = op_row_p; q = op_row_q; c = op_col; idx = op_idx;
    if (pulse_start) start = 1'b1;
    if (stall > 0) begin
      op_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        if (op_valid !== 1'b1 || {op_mode, op_row_p, op_row_q, op_col, op_idx} !== {m, p, q, c, idx})
          stable = 1'b0;
      end
      op_ready = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    op_done = 1'b1;
    @(negedge clk);
    op_done = 1'b0;
    done_seen = done;
    $display("cmd idx=%0d mode=%0d p=%0d q=%0d col=%0d stall=%0d", idx, m, p, q, c, stall);
  endtask

  task automatic pulse_start_now;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; op_ready = 1'b1; op_done = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, op_valid, op_mode, op_row_p, op_row_q, op_col, op_idx, err} !== 19'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=0", {busy, done, op_valid, op_mode, op_row_p, op_row_q, op_col, op_idx, err});
    end
`ifdef QR_SCHED_PERF_EN
    total++;
    if (stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_stall_cnt got=%0d want=0", stall_cnt); end
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, op_valid} !== 2'b00) begin bad++; $display("FAIL idle_after_reset got=%b want=00", {busy, op_valid}); end
  endtask

  task automatic test_full_seq;
    bit got, stable, dseen;
    logic m; logic [2:0] p, q; logic [1:0] c; logic [5:0] idx;
    int nvec [4];
    int ndone, nhs;
    nvec = '{0, 0, 0, 0}; ndone = 0; nhs = 0;
    pulse_start_now();
    total++;
    if ({busy, op_valid} !== 2'b11) begin bad++; $display("FAIL start_latency got=%b want=11", {busy, op_valid}); end
    for (int i = 0; i < 60; i++) begin
      serve_cmd(0, 1'b0, got, m, p, q, c, idx, stable, dseen);
      total++;
      if (!got) begin bad++; $display("FAIL full_timeout cmd=%0d got=none want=op_valid", i); break; end
      nhs++;
      if (m == 1'b0) nvec[c]++;
      ndone += int'(dseen);
      total++;
      if ({idx, m, p, q, c} !== {6'(i), exp_mode[i], exp_p[i], exp_q[i], exp_c[i]}) begin
        bad++;
        $display("FAIL full_cmd got=idx%0d m%0d p%0d q%0d c%0d want=idx%0d m%0d p%0d q%0d c%0d",
                 idx, m, p, q, c, i, exp_mode[i], exp_p[i], exp_q[i], exp_c[i]);
      end
      if (i == 0) begin
        total++;
        if ({m, p, q, c} !== {1'b0, 3'd6, 3'd7, 2'd0}) begin bad++; $display("FAIL cmd0 got=%b want=0_110_111_00", {m, p, q, c}); end
      end
      if (i == 1) begin
        total++;
        if ({m, p, q, c} !== {1'b1, 3'd6, 3'd7, 2'd1}) begin bad++; $display("FAIL cmd1 got=%b want=1_110_111_01", {m, p, q, c}); end
      end
      if (i == 59) begin
        total++;
        if ({m, p, q, c} !== {1'b0, 3'd3, 3'd4, 2'd3}) begin bad++; $display("FAIL cmd59 got=%b want=0_011_100_11", {m, p, q, c}); end
        total++;
        if ({done, busy} !== 2'b10) begin bad++; $display("FAIL done_cycle got=%b want=10", {done, busy}); end
      end
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL done_one_cycle got=%0b want=0", done); end
    total++;
    if (ndone != 1 || nhs != 60) begin bad++; $display("FAIL done_count got=%0d/%0d want=1/60", ndone, nhs); end
    total++;
    if (nvec[0] != 7 || nvec[1] != 6 || nvec[2] != 5 || nvec[3] != 4) begin
      bad++;
      $display("FAIL vec_per_col got=%0d,%0d,%0d,%0d want=7,6,5,4", nvec[0], nvec[1], nvec[2], nvec[3]);
    end
  endtask

  task automatic test_stall;
    bit got, stable, dseen;
    logic m; logic [2:0] p, q; logic [1:0] c; logic [5:0] idx;
    pulse_start_now();
    for (int i = 0; i < 60; i++) begin
      serve_cmd((i == 10) ? 5 : 0, 1'b0, got, m, p, q, c, idx, stable, dseen);
      if (!got) begin total++; bad++; $display("FAIL stall_timeout cmd=%0d got=none want=op_valid", i); break; end
      if (i == 10) begin
        total++;
        if (!stable) begin bad++; $display("FAIL stall_hold got=changed want=stable"); end
        total++;
        if (idx !== 6'd10) begin bad++; $display("FAIL stall_idx got=%0d want=10", idx); end
      end
      if (i == 11) begin
        total++;
        if (idx !== 6'd11) begin bad++; $display("FAIL after_stall_idx got=%0d want=11", idx); end
      end
    end
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL stall_done got=%0b want=1", done); end
`ifdef QR_SCHED_PERF_EN
    total++;
    if (stall_cnt !== 16'd5) begin bad++; $display("FAIL stall_cnt got=%0d want=5", stall_cnt); end
`endif
    @(negedge clk);
  endtask

  task automatic test_start_ignored;
    bit got, stable, dseen;
    logic m; logic [2:0] p, q; logic [1:0] c; logic [5:0] idx;
    pulse_start_now();
    for (int i = 0; i < 60; i++) begin
      serve_cmd(0, (i == 20), got, m, p, q, c, idx, stable, dseen);
      if (!got) begin total++; bad++; $display("FAIL restart_timeout cmd=%0d got=none want=op_valid", i); break; end
      if (i == 20) begin
        total++;
        if ({busy, err} !== 2'b10) begin bad++; $display("FAIL restart_busy_err got=%b want=10", {busy, err}); end
      end
      if (i == 21) begin
        total++;
        if ({idx, m, p, q, c} !== {6'd21, exp_mode[21], exp_p[21], exp_q[21], exp_c[21]}) begin
          bad++; $display("FAIL restart_next got=idx%0d col%0d want=idx21 col%0d", idx, c, exp_c[21]);
        end
      end
    end
    total++;
    if ({done, err} !== 2'b10) begin bad++; $display("FAIL restart_end got=%b want=10", {done, err}); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    bit got, stable, dseen;
    logic m; logic [2:0] p, q; logic [1:0] c; logic [5:0] idx;
    int served;
    pulse_start_now();
    for (int i = 0; i < 60; i++) begin
      serve_cmd(0, 1'b0, got, m, p, q, c, idx, stable, dseen);
      if (!got) begin total++; bad++; $display("FAIL b2b_timeout cmd=%0d got=none want=op_valid", i); break; end
    end
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL b2b_done got=%0b want=1", done); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if ({busy, op_valid, op_idx, op_mode, op_row_p, op_row_q, op_col} !== {2'b11, 6'd0, 1'b0, 3'd6, 3'd7, 2'd0}) begin
      bad++;
      $display("FAIL b2b_first got=b%0b v%0b idx%0d m%0d p%0d q%0d c%0d want=b1 v1 idx0 m0 p6 q7 c0",
               busy, op_valid, op_idx, op_mode, op_row_p, op_row_q, op_col);
    end
    served = 0;
    for (int i = 0; i < 60; i++) begin
      serve_cmd(0, 1'b0, got, m, p, q, c, idx, stable, dseen);
      if (!got || idx !== 6'(i)) break;
      served++;
    end
    total++;
    if (served != 60 || done !== 1'b1) begin bad++; $display("FAIL b2b_second got=%0d/%0b want=60/1", served, done); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bit got, stable, dseen;
    logic m; logic [2:0] p, q; logic [1:0] c; logic [5:0] idx;
    pulse_start_now();
    for (int i = 0; i < 30; i++) begin
      serve_cmd(0, 1'b0, got, m, p, q, c, idx, stable, dseen);
      if (!got) break;
    end
    for (int w = 0; w < 50 && !op_valid; w++) @(negedge clk);
    total++;
    if ({op_valid, op_idx} !== {1'b1, 6'd30}) begin bad++; $display("FAIL mid_cmd30 got=v%0b idx%0d want=v1 idx30", op_valid, op_idx); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({busy, done, op_valid, op_mode, op_row_p, op_row_q, op_col, op_idx, err} !== 19'd0) begin
      bad++;
      $display("FAIL mid_reset got=%b want=0", {busy, done, op_valid, op_mode, op_row_p, op_row_q, op_col, op_idx, err});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    op_done = 1'b1;
    @(negedge clk);
    op_done = 1'b0;
    total++;
    if ({err, busy, op_valid} !== 3'b100) begin bad++; $display("FAIL late_op_done got=%b want=100", {err, busy, op_valid}); end
    pulse_start_now();
    total++;
    if ({err, busy} !== 2'b01) begin bad++; $display("FAIL err_clear got=%b want=01", {err, busy}); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op_ready = 1'b1; op_done = 1'b0;
    build_model();
    test_reset();
    test_full_seq();
    test_stall();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
